// File: rtl/nn_pkg.sv
// Shared constants and state type for the network output stage.
package nn_pkg;
  localparam int SUM_W     = 22;
  localparam int N_CLASSES = 10;
  localparam int IDX_W     = 4;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic signed [SUM_W-1:0] SUM_MIN  = {1'b1, {(SUM_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_CLASSES - 1);
endpackage

// File: rtl/argmax_classifier_if.sv
// Sum-beat stream in, classification result out. Optional res_margin under ARGMAX_MARGIN_EN.
interface argmax_classifier_if;
  import nn_pkg::*;

  logic                    sum_valid;
  logic                    sum_ready;
  logic signed [SUM_W-1:0] sum_data;
  logic                    sum_last;
  logic                    res_valid;
  logic                    res_ready;
  logic [IDX_W-1:0]        res_class;
  logic signed [SUM_W-1:0] res_max;
  logic                    res_err;
`ifdef ARGMAX_MARGIN_EN
  logic [SUM_W:0]          res_margin;
`endif

  modport slave (
    input  sum_valid, sum_data, sum_last, res_ready,
`ifdef ARGMAX_MARGIN_EN
    output res_margin,
`endif
    output sum_ready, res_valid, res_class, res_max, res_err
  );

  modport master (
    output sum_valid, sum_data, sum_last, res_ready,
`ifdef ARGMAX_MARGIN_EN
    input  res_margin,
`endif
    input  sum_ready, res_valid, res_class, res_max, res_err
  );
endinterface

// File: rtl/argmax_cmp_stage.sv
// One-beat compare/update of running (max, idx[, second]); second tracked only with ARGMAX_MARGIN_EN.
module argmax_cmp_stage
  import nn_pkg::*;
(
  input  logic                    first,
  input  logic signed [SUM_W-1:0] din,
  input  logic [IDX_W-1:0]        din_idx,
  input  logic signed [SUM_W-1:0] max_in,
  input  logic [IDX_W-1:0]        idx_in,
`ifdef ARGMAX_MARGIN_EN
  input  logic signed [SUM_W-1:0] second_in,
  output logic signed [SUM_W-1:0] second_out,
`endif
  output logic signed [SUM_W-1:0] max_out,
  output logic [IDX_W-1:0]        idx_out
);

  // Strict compare: ties keep the earlier index.
  always_comb begin
    max_out = max_in;
    idx_out = idx_in;
    if (first) begin
      max_out = din;
      idx_out = '0;
    end else if (din > max_in) begin
      max_out = din;
      idx_out = din_idx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  always_comb begin
    second_out = second_in;
    if (first)
      second_out = SUM_MIN;
    else if (din > max_in)
      second_out = max_in;
    else if (din > second_in)
      second_out = din;
  end
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Frame argmax over N_CLASSES signed sums with a held valid/ready result.
// Optional res_margin (max minus runner-up) when ARGMAX_MARGIN_EN is defined.
//   state   | meaning
//   COLLECT | accepting sum beats, tracking running max
//   HOLD    | result presented, waiting for res_ready
module argmax_classifier
  import nn_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  argmax_classifier_if.slave bus
);

  localparam logic [0:0] S_COLLECT = COLLECT;
  localparam logic [0:0] S_HOLD    = HOLD;

  logic [0:0]              state, state_d;
  logic [IDX_W-1:0]        cnt;
  logic signed [SUM_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    xfer, at_last, frame_end;
`ifdef ARGMAX_MARGIN_EN
  logic signed [SUM_W-1:0] second_q, second_d;
  logic [SUM_W:0]          margin_d;
`endif

  assign xfer      = bus.sum_valid && bus.sum_ready;
  assign at_last   = (cnt == LAST_IDX);
  assign frame_end = xfer && (bus.sum_last || at_last);

  argmax_cmp_stage u_cmp (
    .first      (cnt == '0),
    .din        (bus.sum_data),
    .din_idx    (cnt),
    .max_in     (max_q),
    .idx_in     (idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second_in  (second_q),
    .second_out (second_d),
`endif
    .max_out    (max_d),
    .idx_out    (idx_d)
  );

`ifdef ARGMAX_MARGIN_EN
  // Sign-extended difference is always non-negative and fits SUM_W+1 bits.
  assign margin_d = {max_d[SUM_W-1], max_d} - {second_d[SUM_W-1], second_d};
`endif

  always_comb begin
    state_d = state;
    if (state == S_COLLECT) begin
      if (frame_end) state_d = S_HOLD;
    end else begin
      if (bus.res_ready) state_d = S_COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_COLLECT;
      bus.sum_ready <= 1'b0;
      bus.res_valid <= 1'b0;
      cnt           <= '0;
      max_q         <= '0;
      idx_q         <= '0;
      bus.res_class <= '0;
      bus.res_max   <= '0;
      bus.res_err   <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q       <= SUM_MIN;
      bus.res_margin <= '0;
`endif
    end else begin
      state         <= state_d;
      bus.sum_ready <= (state_d == S_COLLECT);
      bus.res_valid <= (state_d == S_HOLD);
      if (xfer) begin
        max_q <= max_d;
        idx_q <= idx_d;
`ifdef ARGMAX_MARGIN_EN
        second_q <= second_d;
`endif
        cnt   <= frame_end ? '0 : cnt + IDX_W'(1);
      end
      if (frame_end) begin
        bus.res_class <= idx_d;
        bus.res_max   <= max_d;
        // Short frame (early last) or long frame (no last at N) both flag.
        bus.res_err   <= bus.sum_last ^ at_last;
`ifdef ARGMAX_MARGIN_EN
        bus.res_margin <= margin_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Randomized and directed bench for argmax_classifier against a frame-level reference model.
module tb_argmax_classifier;
  import nn_pkg::*;

  localparam int MIN_I = -(1 <<< (SUM_W - 1));
  localparam int MAX_I = (1 <<< (SUM_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  argmax_classifier_if bus();

  argmax_classifier dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int beats[$];
  bit exp_valid = 1'b0;
  bit exp_ready = 1'b0;
  int exp_class = 0, exp_max = 0, exp_err = 0, exp_margin = 0;
  int rr_mode = 0;
  int fr[16];

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of a closed frame, straight from the beat list.
  task automatic score(input bit last);
    int best = 0;
    for (int i = 1; i < beats.size(); i++)
      if (beats[i] > beats[best]) best = i;
    exp_class = best;
    exp_max   = beats[best];
    exp_err   = (beats.size() == N_CLASSES && last) ? 0 : 1;
`ifdef ARGMAX_MARGIN_EN
    begin
      int sec = MIN_I;
      for (int i = 0; i < beats.size(); i++)
        if (i != best && beats[i] > sec) sec = beats[i];
      exp_margin = exp_max - sec;
    end
`endif
    beats.delete();
  endtask

  // Reference: beats accepted while ready, frame closes on last or at N beats.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats.delete();
      exp_valid = 1'b0;
      exp_ready = 1'b0;
    end else if (!exp_valid) begin
      if (exp_ready && bus.sum_valid) begin
        beats.push_back(int'(bus.sum_data));
        if (bus.sum_last || beats.size() == N_CLASSES) begin
          score(bus.sum_last);
          exp_valid = 1'b1;
          exp_ready = 1'b0;
        end
      end else begin
        exp_ready = 1'b1;
      end
    end else if (bus.res_ready) begin
      exp_valid = 1'b0;
      exp_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_sum_ready", bus.sum_ready, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_class", bus.res_class, 0);
      chk("rst_res_max", bus.res_max, 0);
      chk("rst_res_err", bus.res_err, 0);
`ifdef ARGMAX_MARGIN_EN
      chk("rst_res_margin", bus.res_margin, 0);
`endif
    end else begin
      chk("sum_ready", bus.sum_ready, exp_ready);
      chk("res_valid", bus.res_valid, exp_valid);
      if (exp_valid) begin
        chk("res_class", bus.res_class, exp_class);
        chk("res_max", bus.res_max, exp_max);
        chk("res_err", bus.res_err, exp_err);
`ifdef ARGMAX_MARGIN_EN
        chk("res_margin", bus.res_margin, exp_margin);
`endif
      end
    end
  end

  always @(negedge clk) begin
    case (rr_mode)
      1:       bus.res_ready = 1'b0;
      2:       bus.res_ready = 1'b1;
      default: bus.res_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  function automatic logic signed [SUM_W-1:0] rsum();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 5))
      0:       return SUM_MIN;
      1:       return ~SUM_MIN;
      2:       return SUM_W'($urandom_range(0, 6)) - SUM_W'(3);
      default: return r[SUM_W-1:0];
    endcase
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the beat is taken.
  task automatic send(input logic signed [SUM_W-1:0] v, input logic last);
    int n = 0;
    bus.sum_valid = 1'b1;
    bus.sum_data  = v;
    bus.sum_last  = last;
    while (n < 200) begin
      @(negedge clk);
      if (bus.sum_ready) break;
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no sum_ready in %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
    bus.sum_valid = 1'b0;
  endtask

  task automatic send_list(input int n, input bit last_at_end);
    for (int i = 0; i < n; i++)
      send(SUM_W'(fr[i]), last_at_end && (i == n - 1));
  endtask

  task automatic expect_res(input string tag, input int cls, input int mx, input int err);
    chk({tag, "_valid"}, bus.res_valid, 1);
    chk({tag, "_class"}, bus.res_class, cls);
    chk({tag, "_max"}, bus.res_max, mx);
    chk({tag, "_err"}, bus.res_err, err);
    chk({tag, "_model_class"}, exp_class, cls);
    chk({tag, "_model_max"}, exp_max, mx);
  endtask

  initial begin
    bus.sum_valid = 1'b0;
    bus.sum_data  = '0;
    bus.sum_last  = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    fr = '{10, 20, 5, -3, 7, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
    send_list(10, 1'b1);
    expect_res("basic", 1, 20, 0);

    for (int i = 0; i < 10; i++) fr[i] = MIN_I;
    send_list(10, 1'b1);
    expect_res("allmin", 0, MIN_I, 0);
`ifdef ARGMAX_MARGIN_EN
    chk("allmin_margin", bus.res_margin, 0);
`endif

    send(SUM_W'(0), 1'b0);
    rr_mode = 1;
    for (int i = 1; i < 10; i++) send(SUM_W'(i), i == 9);
    expect_res("hold", 9, 9, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_sum_ready", bus.sum_ready, 0);
      chk("hold_class", bus.res_class, 9);
      chk("hold_max", bus.res_max, 9);
    end
    #1 rr_mode = 2;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("post_hs_sum_ready", bus.sum_ready, 1);
    chk("post_hs_res_valid", bus.res_valid, 0);
    rr_mode = 0;

    fr = '{100, 300, 200, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_list(4, 1'b1);
    expect_res("short", 1, 300, 1);
    fr = '{10, 20, 5, -3, 7, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
    send_list(10, 1'b1);
    expect_res("after_short", 1, 20, 0);

    fr = '{1, 2, 3, 4, 500, 6, 7, 8, 9, 10, 0, 0, 0, 0, 0, 0};
    send_list(5, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) fr[i] = 9 - i;
    send_list(10, 1'b1);
    expect_res("after_rst", 0, 9, 0);

`ifdef ARGMAX_MARGIN_EN
    fr = '{MAX_I, MIN_I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_list(10, 1'b1);
    expect_res("margin", 0, MAX_I, 0);
    chk("margin_value", bus.res_margin, MAX_I);
`endif

    for (int f = 0; f < 60; f++) begin
      int len = $urandom_range(1, 13);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        send(rsum(), i == len - 1);
      end
    end

    rr_mode = 2;
    repeat (6) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Sits at the output end of the network datapath and consumes the signed 22-bit neuron sums produced by the adder tree, one output neuron per beat.
- Scans a frame of N_CLASSES sums, tracks the maximum value and its index, and presents the recognised digit on a valid/ready result port.
- Holds each result until the downstream consumer (display or host register) accepts it.

Parameters:
- SUM_W, 22, width of the signed neuron sum (adder-tree output width).
- N_CLASSES, 10, number of output neurons per frame.
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= N_CLASSES.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset, asynchronous assert and active-low.
- sum_valid, input, 1, the sum_* beat is valid.
- sum_ready, output, 1, the block accepts a sum beat.
- sum_data, input, SUM_W, signed neuron sum.
- sum_last, input, 1, marks the final neuron of the frame.
- res_valid, output, 1, the result fields are valid.
- res_ready, input, 1, the consumer accepts the result.
- res_class, output, IDX_W, index of the maximum sum.
- res_max, output, SUM_W, signed maximum sum.
- res_err, output, 1, frame length differed from N_CLASSES.

Behaviour:
- Reset: every output is 0 (sum_ready=0, res_valid=0, res_class=0, res_max=0, res_err=0). Internal beat counter is 0. FSM enters COLLECT; sum_ready rises in the first cycle after reset is released.
- The FSM has two states, COLLECT and HOLD.
  - In COLLECT, sum_ready=1 and res_valid=0.
  - In HOLD, sum_ready=0 and res_valid=1.
- A transfer occurs when sum_valid&&sum_ready. On a transfer:
  - If cnt==0, load max=sum_data and idx=0.
  - Otherwise, if sum_data > max (signed, strict), load max=sum_data and idx=cnt.
  - Strict comparison means ties keep the lowest index.
- Frame end occurs on the transfer where sum_last=1 or cnt==N_CLASSES-1. At frame end:
  - The next state is HOLD.
  - res_class, res_max and res_err are registered so they are valid in the cycle after the final beat. Latency is 1 cycle.
  - cnt clears to 0.
- Otherwise a transfer increments cnt.
- res_err=1 in either mismatch case:
  - sum_last arrives with cnt < N_CLASSES-1 (short frame; the result is still produced).
  - cnt reaches N_CLASSES-1 with sum_last=0 (long frame). The frame is closed and the next beat starts a new frame.
- Handshake rules:
  - The result fields are stable while res_valid=1 and res_ready=0.
  - A handshake in HOLD returns the FSM to COLLECT next cycle; there is no combinational ready path, so one bubble cycle follows each frame.
  - sum_valid in HOLD is ignored. The producer must hold the beat per valid/ready rules.
- Reset mid-frame or mid-HOLD discards the partial frame and any pending result.
- Arithmetic: comparison only, no addition on the max path. Full SUM_W signed range is supported, including -2^(SUM_W-1).

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- Defined:
  - Adds output res_margin, width SUM_W+1, unsigned, equal to max minus second-largest value of the frame.
  - Second-largest tracking:
    - Initialised to -2^(SUM_W-1) at cnt==0.
    - On a new max, second takes the old max.
    - Otherwise, if sum_data > second, second takes sum_data.
  - A tie with max gives margin 0.
  - The SUM_W+1 width makes overflow impossible.
  - res_margin registers alongside res_max and resets to 0.
- Undefined: no port and no second-max logic.

Decomposition:
- Shared package, nn_pkg:
  - SUM_W, N_CLASSES, IDX_W constants.
  - A state enum {COLLECT, HOLD}.
- One natural sub-module, argmax_cmp_stage: the combinational compare/update of (max, idx, second) for one beat. It is reused by future parallel-compare variants.

Test Plan:
- Frame 10,20,5,-3,7,0,1,2,3,4 with last on beat 9 → res_class=1, res_max=20, res_err=0, res_valid the cycle after beat 9.
- All ten sums = -2097152 → res_class=0, res_max=-2097152. With ARGMAX_MARGIN_EN, res_margin=0.
- Sums 0..9 ascending, res_ready held low 5 cycles → outputs stable, sum_ready=0 throughout, then a new frame is accepted after the handshake plus 1 bubble.
- sum_last on beat 3 of 100,300,200,50 → res_class=1, res_max=300, res_err=1. The next frame is counted from 0.
- Reset asserted after beat 4 of a frame, then a clean frame 9,8,...,0 → res_class=0, res_max=9, res_err=0.
- ARGMAX_MARGIN_EN with frame 2097151,-2097152,0,... → res_class=0, res_margin=2097151.
